spi_flash_rd_seq: RTL
=====================

Name: spi_flash_rd_seq

Overview:
- APB-master sequencer that drives the SPI controller's APB slave port to run complete flash read transactions without CPU involvement.
- Accepts a read request (flash address, word count, std/quad), programs CLKDIV/CMD/ADDR/LEN/DUMMY, triggers the transfer, drains the RX FIFO, and streams words out on a valid/ready port.
- Sits between a boot/XIP-fill or DMA requester and the SPI controller.

Parameters:
- APB_ADDR_WIDTH, 12, width of m_paddr.
- BASE_ADDR, 0, SPI controller base address; register offsets are added to it.
- CLK_DIV, 8'd2, value written to CLKDIV.
- CMD_STD, 8'h03, opcode for standard read.
- CMD_QUAD, 8'hEB, opcode for quad read.
- DUMMY_QUAD, 16'd6, dummy read cycles for quad read; standard read uses 0.
- CS_SEL, 2, chip-select index (0..3).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  24  flash byte address
- req_nwords  in  11  word count; 0 is illegal
- req_quad  in  1  1 = quad read
- rsp_valid  out  1  read word valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  32  read word
- done  out  1  one-cycle pulse at transaction end
- err  out  1  qualifies done; 1 = failed transaction
- busy  out  1  high whenever not IDLE
- m_paddr  out  APB_ADDR_WIDTH  APB master address
- m_pwdata  out  32  APB write data
- m_pwrite  out  1  APB write strobe
- m_psel  out  1  APB select
- m_penable  out  1  APB enable
- m_prdata  in  32  APB read data
- m_pready  in  1  APB ready
- m_pslverr  in  1  APB slave error

Behaviour:
- Reset: all outputs 0 except req_ready=1; FSM = IDLE; counters cleared.
- Handshakes:
  - Request accepted on req_valid & req_ready; addr, nwords and quad are latched.
  - APB access: one SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until m_pready. Minimum 2 cycles per access.
- Register offsets: STATUS 0x00, CLKDIV 0x04, SPICMD 0x08, SPIADR 0x0C, SPILEN 0x10, SPIDUM 0x14, RXFIFO 0x20.
- Register write sequence:
  - CLKDIV = CLK_DIV.
  - SPICMD = {opcode, 24'h0}.
  - SPIADR = {addr, 8'h0}.
  - SPILEN = {nwords*32 in [31:16], 6'd24 in [13:8], 6'd8 in [5:0]}; computed in 16 bits, no overflow for nwords ≤ 2047.
  - SPIDUM = {16'h0, dummy}.
  - STATUS = {20'h0, 1<<CS_SEL in [11:8], 8'h04 if quad else 8'h01}.
- FSM: IDLE -> WR_CLKDIV -> WR_CMD -> WR_ADR -> WR_LEN -> WR_DUM -> WR_GO -> POLL -> RD_FIFO -> (POLL | WAIT_IDLE) -> DONE -> IDLE.
  - POLL: reads STATUS. If [23:16] (RX elements) ≠ 0 and the output slot is free, go to RD_FIFO; otherwise re-poll.
  - RD_FIFO: reads RXFIFO into the output register, sets rsp_valid, decrements the remaining-word count. Count 0 -> WAIT_IDLE, else -> POLL.
  - WAIT_IDLE: reads STATUS until bit0 (controller idle) = 1.
  - DONE: done=1 for one cycle, err=0.
- Output: single 32-bit slot. rsp_valid is held until rsp_ready. No RXFIFO read is issued while the slot is full (backpressure).
- Slot-free rule: a slot popped in the same cycle as the POLL decision counts as free.
- Error: m_pslverr on any completed access -> ERR_RST, which writes STATUS = 0x10 (swrst). Then DONE with err=1. A pslverr during ERR_RST is ignored. Pending rsp data is dropped (rsp_valid cleared).
- done and err may coincide with rsp_valid for the last word.
- Reset mid-operation: immediate return to IDLE; an APB transfer is abandoned with psel=0.

Optional Feature:
- Macro SPI_SEQ_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles in POLL/WAIT_IDLE without progress, reloaded on each word read. Reaching 16'hFFFF -> ERR_RST -> done with err=1.
- Undefined: no watchdog; polling is unbounded.

Decomposition:
- Package spi_seq_pkg holds:
  - register offset localparams;
  - STATUS field positions (rd=0, qrd=2, swrst=4, cs=[11:8], rx_elems=[23:16], idle=0);
  - FSM state enum typedef.
- Sub-module spi_apb_mst: single-access APB master engine.
  - Inputs: start, addr, wdata, write.
  - Outputs: rdata, ack, slverr.
  - The FSM sequences this engine.

Test Plan:
- Std read, addr 0x012345, nwords 1, rsp_ready=1 -> writes in order: CLKDIV=0x02, SPICMD=0x03000000, SPIADR=0x01234500, SPILEN=0x00201808, SPIDUM=0, STATUS=0x401. rsp_data equals the RXFIFO read; done=1, err=0.
- Quad read, nwords 4 -> SPICMD=0xEB000000, SPIDUM=0x6, SPILEN=0x00801808, STATUS=0x404. Exactly 4 rsp beats, then done.
- rsp_ready held low 50 cycles during a 3-word read -> no second RXFIFO read until the slot is popped; all words delivered in order.
- m_pslverr on the SPIADR write -> next access is a STATUS write of 0x10, then done=1, err=1, no rsp beats.
- HRESETn asserted during POLL -> all outputs back to reset values within the reset cycle; a new request after release completes normally.
- With SPI_SEQ_TIMEOUT_EN, STATUS RX elements stuck at 0 -> done with err=1 after 65535 cycles.

Source files
------------

// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_pkg
//  Description : Shared definitions for the SPI flash read sequencer:
//                SPI controller register offsets, STATUS field positions and
//                the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    // SPI controller register offsets (relative to BASE_ADDR)
    localparam logic [7:0] c_reg_status = 8'h00;
    localparam logic [7:0] c_reg_clkdiv = 8'h04;
    localparam logic [7:0] c_reg_spicmd = 8'h08;
    localparam logic [7:0] c_reg_spiadr = 8'h0C;
    localparam logic [7:0] c_reg_spilen = 8'h10;
    localparam logic [7:0] c_reg_spidum = 8'h14;
    localparam logic [7:0] c_reg_rxfifo = 8'h20;

    // STATUS field positions
    localparam int c_stat_rd     = 0;   // start standard read (write)
    localparam int c_stat_qrd    = 2;   // start quad read (write)
    localparam int c_stat_swrst  = 4;   // software reset (write)
    localparam int c_stat_cs_lsb = 8;
    localparam int c_stat_cs_msb = 11;
    localparam int c_stat_rx_lsb = 16;  // RX FIFO element count (read)
    localparam int c_stat_rx_msb = 23;
    localparam int c_stat_idle   = 0;   // controller idle (read)

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_CLKDIV = 4'd1,
        S_WR_CMD    = 4'd2,
        S_WR_ADR    = 4'd3,
        S_WR_LEN    = 4'd4,
        S_WR_DUM    = 4'd5,
        S_WR_GO     = 4'd6,
        S_POLL      = 4'd7,
        S_RD_FIFO   = 4'd8,
        S_WAIT_IDLE = 4'd9,
        S_ERR_RST   = 4'd10,
        S_DONE      = 4'd11
    } seq_state_t;

endpackage : spi_seq_pkg
`default_nettype wire

// File: rtl/spi_apb_mst.sv
`default_nettype none
// ============================================================================
//  Module      : spi_apb_mst
//  Description : Single-access APB master engine. A start pulse while idle
//                captures address/data/direction and runs one SETUP + ACCESS
//                transfer; ack pulses in the cycle the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_apb_mst #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [APB_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               wdata,
    input  logic                      write,
    output logic [31:0]               rdata,
    output logic                      ack,
    output logic                      slverr,
    output logic [APB_ADDR_WIDTH-1:0] m_paddr,
    output logic [31:0]               m_pwdata,
    output logic                      m_pwrite,
    output logic                      m_psel,
    output logic                      m_penable,
    input  logic [31:0]               m_prdata,
    input  logic                      m_pready,
    input  logic                      m_pslverr
);

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_SETUP  = 2'd1,
        A_ACCESS = 2'd2
    } apb_state_t;

    apb_state_t                r_state;
    apb_state_t                w_next;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wdata;
    logic                      r_write;

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= A_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: SETUP always lasts one cycle, ACCESS waits for pready
    always_comb begin
        w_next = r_state;
        case (r_state)
            A_IDLE:   if (start)    w_next = A_SETUP;
            A_SETUP:                w_next = A_ACCESS;
            A_ACCESS: if (m_pready) w_next = A_IDLE;
            default:                w_next = A_IDLE;
        endcase
    end

    // Capture the access attributes when a transfer is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (r_state == A_IDLE && start) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_write <= write;
        end
    end

    assign m_psel    = (r_state != A_IDLE);
    assign m_penable = (r_state == A_ACCESS);
    assign m_paddr   = r_addr;
    assign m_pwdata  = r_wdata;
    assign m_pwrite  = r_write & m_psel;
    assign ack       = m_penable & m_pready;
    assign slverr    = ack & m_pslverr;
    assign rdata     = m_prdata;

endmodule : spi_apb_mst
`default_nettype wire

// File: rtl/spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_rd_seq
//  Description : APB-master sequencer running complete SPI flash reads:
//                programs the controller, triggers the transfer, drains the
//                RX FIFO into a single-slot valid/ready output.
//                Optional watchdog on polling: define SPI_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_rd_seq
    import spi_seq_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR      = 0,
    parameter logic [7:0]  CLK_DIV        = 8'd2,
    parameter logic [7:0]  CMD_STD        = 8'h03,
    parameter logic [7:0]  CMD_QUAD       = 8'hEB,
    parameter logic [15:0] DUMMY_QUAD     = 16'd6,
    parameter int          CS_SEL         = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [23:0]               req_addr,
    input  logic [10:0]               req_nwords,
    input  logic                      req_quad,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_data,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] m_paddr,
    output logic [31:0]               m_pwdata,
    output logic                      m_pwrite,
    output logic                      m_psel,
    output logic                      m_penable,
    input  logic [31:0]               m_prdata,
    input  logic                      m_pready,
    input  logic                      m_pslverr
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [23:0] r_addr;
    logic [10:0] r_nwords;
    logic [10:0] r_remain;
    logic        r_quad;
    logic        r_err;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic [7:0]  w_off;
    logic [31:0] w_wdata;
    logic        w_write;
    logic        w_access;
    logic        w_start;
    logic [31:0] w_rdata;
    logic        w_ack;
    logic        w_slverr;
    logic        w_slot_free;
    logic        w_rx_avail;
    logic        w_wdog_exp;
    logic [31:0] w_go;
    logic [3:0]  w_cs;
    logic [APB_ADDR_WIDTH-1:0] w_paddr;

    assign w_cs        = 4'b0001 << CS_SEL;
    assign w_paddr     = APB_ADDR_WIDTH'(BASE_ADDR) + APB_ADDR_WIDTH'(w_off);
    assign w_start     = w_access & ~m_psel;
    assign w_slot_free = ~r_rsp_valid | rsp_ready;
    assign w_rx_avail  = (w_rdata[c_stat_rx_msb:c_stat_rx_lsb] != 8'h00);

    // Controller launch word: chip select plus std/quad read start bit
    always_comb begin
        w_go = '0;
        w_go[c_stat_cs_msb:c_stat_cs_lsb] = w_cs;
        w_go[c_stat_qrd] = r_quad;
        w_go[c_stat_rd]  = ~r_quad;
    end

    spi_apb_mst #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
    ) u_apb (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .start     (w_start),
        .addr      (w_paddr),
        .wdata     (w_wdata),
        .write     (w_write),
        .rdata     (w_rdata),
        .ack       (w_ack),
        .slverr    (w_slverr),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_pwrite  (m_pwrite),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] r_wdog;

    // Watchdog: counts polling cycles, reloaded whenever a word is read
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wdog <= '0;
        end else if (r_state == S_POLL || r_state == S_WAIT_IDLE) begin
            if (r_wdog != 16'hFFFF) r_wdog <= r_wdog + 16'd1;
        end else if (r_state != S_RD_FIFO || w_ack) begin
            r_wdog <= '0;
        end
    end

    assign w_wdog_exp = (r_wdog == 16'hFFFF);
`else
    assign w_wdog_exp = 1'b0;
`endif

    // Sequencer state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and APB access selection; each access state waits for ack
    always_comb begin
        w_next   = r_state;
        w_off    = c_reg_status;
        w_wdata  = '0;
        w_write  = 1'b0;
        w_access = 1'b0;
        case (r_state)
            S_IDLE: if (req_valid) w_next = S_WR_CLKDIV;
            S_WR_CLKDIV: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_clkdiv;
                w_wdata  = {24'h0, CLK_DIV};
                if (w_ack) w_next = S_WR_CMD;
            end
            S_WR_CMD: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_spicmd;
                w_wdata  = {(r_quad ? CMD_QUAD : CMD_STD), 24'h0};
                if (w_ack) w_next = S_WR_ADR;
            end
            S_WR_ADR: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_spiadr;
                w_wdata  = {r_addr, 8'h0};
                if (w_ack) w_next = S_WR_LEN;
            end
            S_WR_LEN: begin
                // data bits in [31:16], 24 address bits, 8 command bits
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_spilen;
                w_wdata  = {r_nwords, 5'b0, 2'b0, 6'd24, 2'b0, 6'd8};
                if (w_ack) w_next = S_WR_DUM;
            end
            S_WR_DUM: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_spidum;
                w_wdata  = {16'h0, (r_quad ? DUMMY_QUAD : 16'h0)};
                if (w_ack) w_next = S_WR_GO;
            end
            S_WR_GO: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_status;
                w_wdata  = w_go;
                if (w_ack) w_next = S_POLL;
            end
            S_POLL: begin
                w_access = 1'b1;
                if (w_ack) begin
                    if (w_rx_avail && w_slot_free) w_next = S_RD_FIFO;
                    else if (w_wdog_exp)           w_next = S_ERR_RST;
                end
            end
            S_RD_FIFO: begin
                w_access = 1'b1; w_off = c_reg_rxfifo;
                if (w_ack) w_next = (r_remain == 11'd1) ? S_WAIT_IDLE : S_POLL;
            end
            S_WAIT_IDLE: begin
                w_access = 1'b1;
                if (w_ack) begin
                    if (w_rdata[c_stat_idle]) w_next = S_DONE;
                    else if (w_wdog_exp)      w_next = S_ERR_RST;
                end
            end
            S_ERR_RST: begin
                w_access = 1'b1; w_write = 1'b1; w_off = c_reg_status;
                w_wdata  = 32'h1 << c_stat_swrst;
                if (w_ack) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Any failed access aborts into the controller reset, except the reset itself
        if (w_slverr && r_state != S_ERR_RST) w_next = S_ERR_RST;
    end

    // Request capture, word counting, output slot and error flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr      <= '0;
            r_nwords    <= '0;
            r_remain    <= '0;
            r_quad      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_addr   <= req_addr;
                r_nwords <= req_nwords;
                r_remain <= req_nwords;
                r_quad   <= req_quad;
                r_err    <= 1'b0;
            end
            if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
            if (r_state == S_RD_FIFO && w_ack && !w_slverr) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rdata;
                r_remain    <= r_remain - 11'd1;
            end
            if (w_next == S_ERR_RST && r_state != S_ERR_RST) begin
                r_err       <= 1'b1;
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) & r_err;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule : spi_flash_rd_seq
`default_nettype wire
